// File: rtl/jackpot_pkg.sv
// rtl/jackpot_pkg.sv - shared state encoding, mode encodings and counter helpers for jackpot_n
package jackpot_pkg;

  typedef enum logic {
    RUN = 1'b0,
    WIN = 1'b1
  } state_t;

  localparam int MODE_ROTATE = 0;
  localparam int MODE_BOUNCE = 1;
  localparam int CNT_W       = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider: one-cycle tick every DIV clocks, held at 0 while hold is high
module tick_gen #(
  parameter int DIV = 31250000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (hold || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jackpot_n.sv
// rtl/jackpot_n.sv - reaction game: moving lit LED, press the matching switch to win
// Optional switch filtering enabled by defining JACKPOT_DEBOUNCE_EN.
module jackpot_n
  import jackpot_pkg::*;
#(
  parameter int N_LEDS          = 4,
  parameter int TICK_DIV        = 31250000,
  parameter int MODE            = 0,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] sw,
  output logic [N_LEDS-1:0] led,
  output logic              win,
  output logic [CNT_W-1:0]  win_count,
  output logic [CNT_W-1:0]  miss_count
);

  if (N_LEDS < 2 || N_LEDS > 16 || TICK_DIV < 2 || DEBOUNCE_CYCLES < 1 ||
      (MODE != MODE_ROTATE && MODE != MODE_BOUNCE)) begin : g_bad_cfg
    $error("jackpot_n: illegal parameter value");
  end

  logic [N_LEDS-1:0] sync1_q, sync2_q, prev_q, level, rise;
  state_t            state_q, state_d;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              dir_up_q, dir_up_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d, miss_cnt_q, miss_cnt_d;
  logic              tick, win_hit, win_exit, hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef JACKPOT_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0]   db_cnt_q [N_LEDS];
  logic [DB_W-1:0]   db_cnt_d [N_LEDS];
  logic [N_LEDS-1:0] filt_q, filt_d;

  // A bit's filtered level follows only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < N_LEDS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) filt_d[i] = sync2_q[i];
        else                                            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < N_LEDS; i++) db_cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < N_LEDS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign rise     = level & ~prev_q;
  assign win_hit  = (state_q == RUN) && (|(rise & led_q));
  assign win_exit = (state_q == WIN) && (level == '0);
  // Divider is cleared on the entry edge itself so it sits at 0 for the whole WIN stay.
  assign hold     = win_hit || ((state_q == WIN) && !win_exit);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    dir_up_d   = dir_up_q;
    win_cnt_d  = win_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      RUN: begin
        if (win_hit) begin
          state_d   = WIN;
          led_d     = '1;
          win_cnt_d = sat_inc(win_cnt_q);
        end else begin
          if (|rise) miss_cnt_d = sat_inc(miss_cnt_q);
          if (tick) begin
            if (MODE == MODE_ROTATE) begin
              led_d = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            end else if (dir_up_q) begin
              led_d = led_q << 1;
              if (led_d[N_LEDS-1]) dir_up_d = 1'b0;
            end else begin
              led_d = led_q >> 1;
              if (led_d[0]) dir_up_d = 1'b1;
            end
          end
        end
      end
      WIN: begin
        led_d = '1;
        if (win_exit) begin
          state_d  = RUN;
          led_d    = N_LEDS'(1);
          dir_up_d = 1'b1;
        end
      end
      default: begin
        state_d  = RUN;
        led_d    = N_LEDS'(1);
        dir_up_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      led_q      <= N_LEDS'(1);
      dir_up_q   <= 1'b1;
      win_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      dir_up_q   <= dir_up_d;
      win_cnt_q  <= win_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign led        = led_q;
  assign win        = (state_q == WIN);
  assign win_count  = win_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_jackpot_n.sv
// tb/tb_jackpot_n.sv - directed self-checking bench for jackpot_n (rotate and bounce instances)
module tb_jackpot_n;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw0 = '0, sw1 = '0;
  logic [3:0] led0, led1;
  logic       win0, win1;
  logic [7:0] wc0, mc0, wc1, mc1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  jackpot_n #(.N_LEDS(4), .TICK_DIV(4), .MODE(0), .DEBOUNCE_CYCLES(8)) dut0 (
    .clk(clk), .reset(reset), .sw(sw0), .led(led0), .win(win0),
    .win_count(wc0), .miss_count(mc0)
  );

  jackpot_n #(.N_LEDS(4), .TICK_DIV(4), .MODE(1), .DEBOUNCE_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .sw(sw1), .led(led1), .win(win1),
    .win_count(wc1), .miss_count(mc1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge right after the reset edge (relative cycle 0).
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] seq0 [8];
    logic [3:0] seq1 [8];
    seq0 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    @(negedge clk);
    do_reset();
    chk("rst_led0", 16'(led0), 16'h1);
    chk("rst_win0", 16'(win0), 16'h0);
    chk("rst_wc0", 16'(wc0), 16'h0);
    chk("rst_mc0", 16'(mc0), 16'h0);
    chk("rst_led1", 16'(led1), 16'h1);

`ifndef JACKPOT_DEBOUNCE_EN
    step(3);
    chk("led0_hold_c3", 16'(led0), 16'h1);
    step(1);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("rot_seq%0d", k), 16'(led0), 16'(seq0[k]));
      chk($sformatf("bnc_seq%0d", k), 16'(led1), 16'(seq1[k]));
      step(4);
    end

    // winning press on the lit bit, extra press while in WIN, then release
    do_reset();
    step(4);
    chk("w_led_pre", 16'(led0), 16'h2);
    sw0 = 4'b0010;
    step(2);
    chk("w_not_yet", 16'(win0), 16'h0);
    step(1);
    chk("w_led", 16'(led0), 16'hF);
    chk("w_win", 16'(win0), 16'h1);
    chk("w_wc", 16'(wc0), 16'h1);
    sw0 = 4'b1010;
    step(3);
    chk("w_ign_mc", 16'(mc0), 16'h0);
    chk("w_ign_wc", 16'(wc0), 16'h1);
    chk("w_ign_led", 16'(led0), 16'hF);
    sw0 = 4'b0000;
    step(2);
    chk("w_still", 16'(win0), 16'h1);
    step(1);
    chk("x_led", 16'(led0), 16'h1);
    chk("x_win", 16'(win0), 16'h0);
    step(2);
    chk("x_led_c15", 16'(led0), 16'h1);
    step(1);
    chk("x_led_c16", 16'(led0), 16'h2);

    // misses on bit 3, phased so bit 3 is never lit at the press
    do_reset();
    sw0 = 4'b1000;
    step(2);
    chk("m_not_yet", 16'(mc0), 16'h0);
    step(1);
    chk("m_mc1", 16'(mc0), 16'h1);
    chk("m_led_keep", 16'(led0), 16'h1);
    step(1);
    chk("m_led_step", 16'(led0), 16'h2);
    step(4);
    sw0 = 4'b0000;
    step(8);
    for (int i = 2; i <= 300; i++) begin
      sw0 = 4'b1000;
      step(8);
      sw0 = 4'b0000;
      step(8);
      if (i == 254 || i == 255 || i == 256)
        chk($sformatf("m_sat_%0d", i), 16'(mc0), 16'((i > 255) ? 255 : i));
    end
    chk("m_final", 16'(mc0), 16'd255);
    chk("m_wc0", 16'(wc0), 16'h0);

    // winning rise on the tick edge, with a second bit rising alongside
    do_reset();
    step(1);
    sw0 = 4'b0101;
    step(2);
    chk("t_pre", 16'(led0), 16'h1);
    step(1);
    chk("t_led", 16'(led0), 16'hF);
    chk("t_wc", 16'(wc0), 16'h1);
    chk("t_mc", 16'(mc0), 16'h0);
    step(4);
    chk("t_hold", 16'(led0), 16'hF);

    // reset while in WIN
    sw0 = 4'b0000;
    do_reset();
    chk("r_led", 16'(led0), 16'h1);
    chk("r_win", 16'(win0), 16'h0);
    chk("r_wc", 16'(wc0), 16'h0);
`else
    sw0 = 4'b0001;
    step(5);
    sw0 = 4'b0000;
    step(20);
    chk("d_glitch_wc", 16'(wc0), 16'h0);
    chk("d_glitch_mc", 16'(mc0), 16'h0);
    sw0 = 4'b1111;
    step(6);
    chk("d_early", 16'(win0), 16'h0);
    step(14);
    chk("d_win", 16'(win0), 16'h1);
    chk("d_wc", 16'(wc0), 16'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
